alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue and control unit for the ARM data-processing path.
- Accepts one 32-bit data-processing instruction at a time and reads its operands from the register file.
- Evaluates the condition field against an internal NZCV flags register, then drives src1/src2/ctrl_cmd/current_flags into the ALU.
- Captures Rd_out/new_flags, writes back to the register file and updates flags. It is the producer of the ALU command interface.

Parameters:
- XLEN, 32, datapath width (instruction fixed 32).
- NREG, 16, register-file entries; address width 4.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- instr_valid  in  1  instruction offered
- instr  in  32  ARM instruction word
- instr_ready  out  1  high only in IDLE; transfer when valid&ready
- rf_raddr1  out  4  Rn read address
- rf_raddr2  out  4  Rm read address
- rf_rdata1  in  32  Rn data (combinational read)
- rf_rdata2  in  32  Rm data
- src1  out  32  ALU operand 1 (registered)
- src2  out  32  ALU operand 2 (registered)
- ctrl_cmd  out  8  ALU command (registered)
- current_flags  out  4  flags register {N,Z,C,V} to ALU
- Rd_out  in  32  ALU result
- new_flags  in  4  ALU flag result {N,Z,C,V}
- rf_we  out  1  write-back strobe, one cycle
- rf_waddr  out  4  Rd
- rf_wdata  out  32  write-back data
- done  out  1  one-cycle pulse, instruction retired
- skipped  out  1  one-cycle pulse with done: condition failed or illegal
- illegal  out  1  one-cycle pulse with done: bits[27:26]!=00

Behaviour:
- Reset (async, any state):
  - state=IDLE; flags, src1, src2, ctrl_cmd, rf_we, done, skipped and illegal = 0.
  - An in-flight instruction is dropped with no write-back.
- Instruction fields:
  - cond[31:28], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12].
  - Imm8[7:0] with rot[11:8]; operand = Imm8 rotated right by 2*rot.
  - Rm[3:0], shamt[11:7], shtype[6:5]. Bit4=1 (register-specified shift) is illegal.
- ctrl_cmd encoding:
  - [7:6] class: 00 data op, 11 shift.
  - [5] = 0.
  - [4:1] = opcode for a data op; [3:1] = {0,shtype} for shift (000 LSL, 001 LSR, 010 ASR, 011 ROR).
  - [0] = S for a data op, 0 for shift.
  - ctrl_cmd = 0 outside SHIFT/EXEC.
- FSM states: IDLE, DECODE, SHIFT, EXEC, WB.
  - IDLE: instr_ready=1; on handshake latch instr and go to DECODE.
  - DECODE:
    - Drive rf_raddr1=Rn, rf_raddr2=Rm; latch rdata.
    - Evaluate cond on flags using the standard ARM table. 1111 = never.
    - Cond fail or illegal → WB with skip.
    - I=0 and shamt!=0 → SHIFT; otherwise → EXEC.
  - SHIFT: src1=Rm value, src2=shamt zero-extended, class 11. Latch Rd_out as operand2 at end of cycle → EXEC. new_flags ignored.
  - EXEC: src1=Rn value, src2=operand2 (immediate, Rm, or shifted Rm), class 00. Latch Rd_out and new_flags → WB.
  - WB, one cycle:
    - done=1.
    - rf_we=1 unless skipped or opcode in 1000–1011 (TST/TEQ/CMP/CMN).
    - flags<=new_flags if S=1 or opcode in 1000–1011, and not skipped.
    - → IDLE.
- current_flags always shows the flags register; an update in WB is visible from the next cycle.
- Latency, handshake cycle = 0:
  - no shift: done at cycle 3.
  - with shift: done at cycle 4.
  - skipped/illegal: done at cycle 2.
- Throughput: one instruction per latency+1 cycles. instr_valid during busy states is ignored, since ready is low.
- Rd=Rn or Rd=Rm is legal: operands are latched in DECODE.
- Rd=15 is written like any other register; there is no branch side effect.

Test Plan:
- Reset with R0=194, R1=204, ADD R2,R0,R1 (0xE0802001) → cycle 2: ctrl_cmd=0x08, src1=194, src2=204. Cycle 3: rf_we=1, rf_waddr=2, rf_wdata=398, done=1. flags remain 0 (S=0).
- MOV R3,#0xFF ror 8 (0xE3A034FF) → src2=0xFF000000, ctrl_cmd=0x1A, rf_wdata=0xFF000000.
- ADD R4,R0,R1,LSL #2 (0xE0804101) → cycle 2: ctrl_cmd=0xC0, src1=204, src2=2. Cycle 3: ctrl_cmd=0x08, src2=816. Cycle 4: rf_wdata=1010.
- CMP R0,R0 (0xE1500000) with ALU new_flags=0100 → no rf_we, current_flags=0100 next cycle. Then MOVNE R5,#1 → done and skipped at cycle 2, no rf_we, flags unchanged.
- LDR word (0xE5901000) → done, skipped and illegal pulse at cycle 2, no write.
- Assert reset during EXEC of an ADDS → outputs 0 immediately, no rf_we, flags 0, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/control unit for the ARM data-processing path.
// Accepts one instruction at a time, reads operands from the register file,
// checks the condition field against the internal NZCV register, sequences an
// optional shifter pass and the ALU pass, then writes back and updates flags.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready for a new instruction (instr_ready=1)
// DECODE | read Rn/Rm, evaluate condition and legality, load ALU operands
// SHIFT  | ALU shifts Rm by the immediate amount; result becomes operand 2
// EXEC   | ALU performs the data op; result and flags are captured
// WB     | one-cycle retire: done pulse, optional write-back and flag update
module alu_issue_ctrl #(
   parameter int XLEN = 32,
   parameter int NREG = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    instr_valid,
   input  logic [31:0]             instr,
   output logic                    instr_ready,
   output logic [$clog2(NREG)-1:0] rf_raddr1,
   output logic [$clog2(NREG)-1:0] rf_raddr2,
   input  logic [XLEN-1:0]         rf_rdata1,
   input  logic [XLEN-1:0]         rf_rdata2,
   output logic [XLEN-1:0]         src1,
   output logic [XLEN-1:0]         src2,
   output logic [7:0]              ctrl_cmd,
   output logic [3:0]              current_flags,
   input  logic [XLEN-1:0]         Rd_out,
   input  logic [3:0]              new_flags,
   output logic                    rf_we,
   output logic [$clog2(NREG)-1:0] rf_waddr,
   output logic [XLEN-1:0]         rf_wdata,
   output logic                    done,
   output logic                    skipped,
   output logic                    illegal
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      SHIFT  = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t          state;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] rn_val;
   logic [3:0]      flags;
   logic [3:0]      wb_flags;
   logic            wb_skip;

   // instruction fields, all taken from the latched word
   logic [3:0] f_cond;
   logic [1:0] f_class;
   logic       f_i;
   logic [3:0] f_opcode;
   logic       f_s;
   logic [4:0] f_shamt;
   logic [1:0] f_shtype;
   logic       f_regshift;
   logic [3:0] f_rot;
   logic [7:0] f_imm8;

   assign f_cond     = instr_q[31:28];
   assign f_class    = instr_q[27:26];
   assign f_i        = instr_q[25];
   assign f_opcode   = instr_q[24:21];
   assign f_s        = instr_q[20];
   assign f_rot      = instr_q[11:8];
   assign f_shamt    = instr_q[11:7];
   assign f_shtype   = instr_q[6:5];
   assign f_regshift = instr_q[4];
   assign f_imm8     = instr_q[7:0];

   assign rf_raddr1 = instr_q[19:16];
   assign rf_raddr2 = instr_q[3:0];
   assign rf_waddr  = instr_q[15:12];

   assign instr_ready   = (state == IDLE);
   assign current_flags = flags;

   logic fl_n, fl_z, fl_c, fl_v;
   assign fl_n = flags[3];
   assign fl_z = flags[2];
   assign fl_c = flags[1];
   assign fl_v = flags[0];

   // register-specified shifts are not supported and are retired as illegal
   logic is_illegal;
   logic is_test;
   logic needs_shift;
   logic upd_flags;

   assign is_illegal  = (f_class != 2'b00) || (!f_i && f_regshift);
   assign is_test     = (f_opcode[3:2] == 2'b10);
   assign needs_shift = !f_i && (f_shamt != 5'd0);
   assign upd_flags   = f_s || is_test;

   logic [7:0] data_cmd;
   logic [7:0] shift_cmd;

   assign data_cmd  = {2'b00, 1'b0, f_opcode, f_s};
   assign shift_cmd = {2'b11, 1'b0, 2'b00, f_shtype, 1'b0};

   // immediate operand: imm8 rotated right by twice the rotate field
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] imm_rot;
   logic [XLEN-1:0] shamt_ext;
   logic [5:0]      rot_amt;
   logic [6:0]      rot_lsh;

   assign imm_ext   = {{(XLEN-8){1'b0}}, f_imm8};
   assign shamt_ext = {{(XLEN-5){1'b0}}, f_shamt};
   assign rot_amt   = {1'b0, f_rot, 1'b0};
   assign rot_lsh   = 7'(XLEN) - {1'b0, rot_amt};
   assign imm_rot   = (imm_ext >> rot_amt) | (imm_ext << rot_lsh);

   logic cond_pass;

   // standard ARM condition table; 1111 never executes
   always_comb begin
      cond_pass = 1'b0;
      case (f_cond)
         4'b0000: cond_pass = fl_z;
         4'b0001: cond_pass = !fl_z;
         4'b0010: cond_pass = fl_c;
         4'b0011: cond_pass = !fl_c;
         4'b0100: cond_pass = fl_n;
         4'b0101: cond_pass = !fl_n;
         4'b0110: cond_pass = fl_v;
         4'b0111: cond_pass = !fl_v;
         4'b1000: cond_pass = fl_c && !fl_z;
         4'b1001: cond_pass = !fl_c || fl_z;
         4'b1010: cond_pass = (fl_n == fl_v);
         4'b1011: cond_pass = (fl_n != fl_v);
         4'b1100: cond_pass = !fl_z && (fl_n == fl_v);
         4'b1101: cond_pass = fl_z || (fl_n != fl_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // issue sequencer; every ALU-facing and retire output is registered here
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         instr_q  <= '0;
         rn_val   <= '0;
         src1     <= '0;
         src2     <= '0;
         ctrl_cmd <= '0;
         flags    <= '0;
         wb_flags <= '0;
         wb_skip  <= 1'b0;
         rf_we    <= 1'b0;
         rf_wdata <= '0;
         done     <= 1'b0;
         skipped  <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  instr_q <= instr;
                  state   <= DECODE;
               end
            end
            DECODE: begin
               // Rn is held here so Rd may alias Rn/Rm without hazard
               rn_val <= rf_rdata1;
               if (is_illegal || !cond_pass) begin
                  wb_skip <= 1'b1;
                  done    <= 1'b1;
                  skipped <= 1'b1;
                  illegal <= is_illegal;
                  state   <= WB;
               end else if (needs_shift) begin
                  src1     <= rf_rdata2;
                  src2     <= shamt_ext;
                  ctrl_cmd <= shift_cmd;
                  state    <= SHIFT;
               end else begin
                  src1     <= rf_rdata1;
                  src2     <= f_i ? imm_rot : rf_rdata2;
                  ctrl_cmd <= data_cmd;
                  state    <= EXEC;
               end
            end
            SHIFT: begin
               // shifter flags are discarded; only the shifted value is kept
               src1     <= rn_val;
               src2     <= Rd_out;
               ctrl_cmd <= data_cmd;
               state    <= EXEC;
            end
            EXEC: begin
               rf_wdata <= Rd_out;
               wb_flags <= new_flags;
               wb_skip  <= 1'b0;
               rf_we    <= !is_test;
               done     <= 1'b1;
               ctrl_cmd <= '0;
               state    <= WB;
            end
            WB: begin
               if (!wb_skip && upd_flags) begin
                  flags <= wb_flags;
               end
               rf_we   <= 1'b0;
               done    <= 1'b0;
               skipped <= 1'b0;
               illegal <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: plays register file and ALU around the DUT, keeps
// an instruction-level reference model, and checks retirements from a queue.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready;
   logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [31:0] src1, src2;
   logic [7:0]  ctrl_cmd;
   logic [3:0]  current_flags;
   logic [31:0] Rd_out;
   logic [3:0]  new_flags;
   logic        rf_we;
   logic [31:0] rf_wdata;
   logic        done, skipped, illegal;

   alu_issue_ctrl #(.XLEN(32), .NREG(16)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .src1(src1), .src2(src2), .ctrl_cmd(ctrl_cmd), .current_flags(current_flags),
      .Rd_out(Rd_out), .new_flags(new_flags),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .done(done), .skipped(skipped), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- register file (preloaded through ld_*) ----------------
   logic [31:0] rf_mem [16];
   logic        ld_en = 1'b0;
   logic [3:0]  ld_a = '0;
   logic [31:0] ld_d = '0;

   always @(posedge clk) begin
      if (ld_en) rf_mem[ld_a] <= ld_d;
      else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
   end
   assign rf_rdata1 = rf_mem[rf_raddr1];
   assign rf_rdata2 = rf_mem[rf_raddr2];

   // ---------------- architectural helpers ----------------
   function automatic logic [31:0] shift_val(input logic [31:0] v, input logic [1:0] typ,
                                             input logic [4:0] n);
      case (typ)
         2'd0: return v << n;
         2'd1: return v >> n;
         2'd2: return $signed(v) >>> n;
         default: return (n == 5'd0) ? v : ((v >> n) | (v << (6'd32 - {1'b0, n})));
      endcase
   endfunction

   function automatic logic [31:0] rot_imm(input logic [7:0] imm, input logic [3:0] rot);
      logic [63:0] t;
      t = {56'd0, imm} << (32 - 2 * int'(rot));
      return t[63:32] | t[31:0];
   endfunction

   // returns {N,Z,C,V,result}
   function automatic logic [35:0] data_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [3:0] f);
      logic [32:0] t;
      logic [31:0] r;
      logic c, v;
      t = '0; r = '0; c = f[1]; v = f[0];
      case (op)
         4'h0, 4'h8: r = a & b;
         4'h1, 4'h9: r = a ^ b;
         4'h2, 4'hA: begin
            t = {1'b0, a} + {1'b0, ~b} + 33'd1; r = t[31:0]; c = t[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'h3: begin
            t = {1'b0, b} + {1'b0, ~a} + 33'd1; r = t[31:0]; c = t[32];
            v = (a[31] != b[31]) && (r[31] != b[31]);
         end
         4'h4, 4'hB: begin
            t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'h5: begin
            t = {1'b0, a} + {1'b0, b} + {32'd0, f[1]}; r = t[31:0]; c = t[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'h6: begin
            t = {1'b0, a} + {1'b0, ~b} + {32'd0, f[1]}; r = t[31:0]; c = t[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'h7: begin
            t = {1'b0, b} + {1'b0, ~a} + {32'd0, f[1]}; r = t[31:0]; c = t[32];
            v = (a[31] != b[31]) && (r[31] != b[31]);
         end
         4'hC: r = a | b;
         4'hD: r = b;
         4'hE: r = a & ~b;
         default: r = ~b;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   function automatic logic cond_ok(input logic [3:0] cnd, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cnd)
         4'h0: return z;            4'h1: return !z;
         4'h2: return c;            4'h3: return !c;
         4'h4: return n;            4'h5: return !n;
         4'h6: return v;            4'h7: return !v;
         4'h8: return c && !z;      4'h9: return !c || z;
         4'hA: return n == v;       4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // ---------------- ALU stand-in (combinational) ----------------
   logic       alu_force = 1'b0;
   logic [3:0] alu_force_val = '0;

   function automatic logic [35:0] alu_fn(input logic [7:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] f);
      if (cmd[7:6] == 2'b11) return {f, shift_val(a, cmd[2:1], b[4:0])};
      return data_op(cmd[4:1], a, b, f);
   endfunction

   always_comb begin
      {new_flags, Rd_out} = alu_fn(ctrl_cmd, src1, src2, current_flags);
      if (alu_force) new_flags = alu_force_val;
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      int         hs;
      int         lat;
      logic       skp;
      logic       ill;
      logic       we;
      logic [3:0] wa;
      logic [31:0] wd;
      logic [3:0] fl;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl_regs [16];
   logic [3:0]  mdl_flags = '0;

   // call at a falling edge with instr_ready high; returns one cycle later
   task automatic issue(input logic [31:0] ins, input logic frc, input logic [3:0] fval);
      exp_t        e;
      logic [31:0] op2;
      logic [35:0] ar;
      logic        ii, tst, shifting;
      ii       = ins[25];
      e.ill    = (ins[27:26] != 2'b00) || (!ii && ins[4]);
      e.skp    = e.ill || !cond_ok(ins[31:28], mdl_flags);
      shifting = !ii && (ins[11:7] != 5'd0);
      if (ii) op2 = rot_imm(ins[7:0], ins[11:8]);
      else if (shifting) op2 = shift_val(mdl_regs[ins[3:0]], ins[6:5], ins[11:7]);
      else op2 = mdl_regs[ins[3:0]];
      ar   = data_op(ins[24:21], mdl_regs[ins[19:16]], op2, mdl_flags);
      tst  = (ins[24:23] == 2'b10);
      e.we = !e.skp && !tst;
      e.wa = ins[15:12];
      e.wd = ar[31:0];
      if (e.we) mdl_regs[ins[15:12]] = ar[31:0];
      if (!e.skp && (ins[20] || tst)) mdl_flags = frc ? fval : ar[35:32];
      e.fl  = mdl_flags;
      e.lat = e.skp ? 2 : (shifting ? 4 : 3);
      e.hs  = cyc;
      sb.push_back(e);
      alu_force     = frc;
      alu_force_val = fval;
      instr         = ins;
      instr_valid   = 1'b1;
      @(negedge clk);
      // junk offered while busy must be ignored
      instr_valid = 1'($urandom_range(0, 1));
      instr       = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!instr_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", 32'(instr_ready), 32'd1);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      w = $urandom;
      w[31:28] = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
      w[27:26] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (!w[25]) begin
         w[4] = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 1) == 0) w[11:7] = 5'd0;
      end
      return w;
   endfunction

   // ---------------- monitor ----------------
   exp_t       mon_e;
   logic       fl_pend = 1'b0;
   logic [3:0] fl_exp = '0;

   // compares each retirement against the head of the queue
   always @(negedge clk) begin
      if (!reset) begin
         if (fl_pend) begin
            chk("flags_after", 32'(current_flags), 32'(fl_exp));
            fl_pend = 1'b0;
         end
         if (rf_we && !done) chk("we_without_done", 32'(rf_we), 32'd0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("done_latency", 32'(cyc - mon_e.hs), 32'(mon_e.lat));
               chk("skipped", 32'(skipped), 32'(mon_e.skp));
               chk("illegal", 32'(illegal), 32'(mon_e.ill));
               chk("rf_we", 32'(rf_we), 32'(mon_e.we));
               if (mon_e.we) begin
                  chk("rf_waddr", 32'(rf_waddr), 32'(mon_e.wa));
                  chk("rf_wdata", rf_wdata, mon_e.wd);
               end
               fl_exp  = mon_e.fl;
               fl_pend = 1'b1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [31:0] r6_old;

   initial begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         ld_d = (i == 0) ? 32'd194 : (i == 1) ? 32'd204 : $urandom;
         ld_a = 4'(i);
         mdl_regs[i] = ld_d;
         ld_en = 1'b1;
         @(negedge clk);
      end
      ld_en = 1'b0;

      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_ctrl", 32'(ctrl_cmd), 32'd0);
      chk("rst_src1", src1, 32'd0);
      chk("rst_src2", src2, 32'd0);
      chk("rst_flags", 32'(current_flags), 32'd0);
      chk("rst_skip_ill", 32'({skipped, illegal}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // ADD R2,R0,R1
      wait_idle();
      issue(32'hE0802001, 1'b0, 4'd0);
      @(negedge clk);
      chk("add_ctrl", 32'(ctrl_cmd), 32'h08);
      chk("add_src1", src1, 32'd194);
      chk("add_src2", src2, 32'd204);

      // MOV R3,#0xFF ror 8
      wait_idle();
      issue(32'hE3A034FF, 1'b0, 4'd0);
      @(negedge clk);
      chk("mov_ctrl", 32'(ctrl_cmd), 32'h1A);
      chk("mov_src2", src2, 32'hFF000000);

      // ADD R4,R0,R1,LSL #2
      wait_idle();
      issue(32'hE0804101, 1'b0, 4'd0);
      @(negedge clk);
      chk("shf_ctrl", 32'(ctrl_cmd), 32'hC0);
      chk("shf_src1", src1, 32'd204);
      chk("shf_src2", src2, 32'd2);
      @(negedge clk);
      chk("shx_ctrl", 32'(ctrl_cmd), 32'h08);
      chk("shx_src1", src1, 32'd194);
      chk("shx_src2", src2, 32'd816);

      // CMP R0,R0 with the ALU reporting Z only, then MOVNE R5,#1 must skip
      wait_idle();
      issue(32'hE1500000, 1'b1, 4'b0100);
      wait_idle();
      chk("cmp_flags", 32'(current_flags), 32'b0100);
      issue(32'h13A05001, 1'b0, 4'd0);
      wait_idle();
      chk("movne_flags", 32'(current_flags), 32'b0100);

      // LDR: not a data-processing op
      issue(32'hE5901000, 1'b0, 4'd0);
      wait_idle();

      for (int k = 0; k < 250; k++) begin
         wait_idle();
         if ($urandom_range(0, 3) == 0) begin
            instr_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         issue(gen_instr(), 1'b0, 4'd0);
      end

      // reset while an ADDS R6,R0,R1 is in EXEC
      wait_idle();
      r6_old = mdl_regs[6];
      issue(32'hE0906001, 1'b0, 4'd0);
      @(negedge clk);
      reset = 1'b1;
      instr_valid = 1'b0;
      #1;
      chk("ar_ctrl", 32'(ctrl_cmd), 32'd0);
      chk("ar_src1", src1, 32'd0);
      chk("ar_src2", src2, 32'd0);
      chk("ar_we_done", 32'({rf_we, done}), 32'd0);
      chk("ar_flags", 32'(current_flags), 32'd0);
      sb.delete();
      mdl_flags = '0;
      mdl_regs[6] = r6_old;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("ar_ready", 32'(instr_ready), 32'd1);
      chk("ar_r6_kept", rf_mem[6], r6_old);
      @(negedge clk);

      wait_idle();
      issue(32'hE0802001, 1'b0, 4'd0);
      wait_idle();

      begin
         int n = 0;
         while ((sb.size() != 0 || fl_pend) && n < 40) begin
            @(negedge clk);
            n++;
         end
      end
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
